mmio_uart_tx: RTL

Memory-mapped UART transmitter on the MIPS data bus, in the MEM stage next to the data RAM. It decodes the same EX/MEM signals that drive the RAM: ALU result as the byte address, write data, MemWrite and MemRead. Stored bytes are queued in a small FIFO and serialized 8N1 on `TxD`, LSB first. A status register is readable through the MEM/WB read-data path and is OR-merged with the RAM read data by the integrator.

---
 rtl/mmio_uart_tx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8N1, LSB first) with a TX FIFO and a STATUS register on the MEM stage.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0100,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        TxD,
    output logic        Busy
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_MAX    = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic push_req, status_rd, empty, full, pop, push, ovf_set;
    logic unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    assign push_req  = MemWrite && (Address == BASE_ADDR);
    assign status_rd = MemRead && (Address == STATUS_ADDR);
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    // A full FIFO still accepts a store when the FSM frees a slot in the same cycle.
    assign push      = push_req && (!full || pop);
    assign ovf_set   = push_req && full && !pop;

    assign ReadData = status_rd ? {24'h0, 4'(count_q), busy_q, ovf_q, full, empty} : 32'h0;
    assign TxD      = txd_q;
    assign Busy     = busy_q;

    // FIFO occupancy and sticky overflow; set beats a same-cycle STATUS read.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (status_rd) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push) begin
                mem_q[wr_ptr_q] <= WriteData[7:0];
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // TX framing FSM; the baud counter reloads on every state or bit change.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    par_d   = ^mem_q[rd_ptr_q];
`endif
                    baud_d  = BAUD_MAX;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_MAX;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_MAX;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_MAX;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
